divider_seq: RTL and testbench
==============================

Name: divider_seq

Overview:
- Iterative restoring divider; the inverse of the 4-bit combinational multiplier.
- Takes a 2*WIDTH-bit dividend (a product) and a WIDTH-bit divisor. Returns a WIDTH-bit quotient and a WIDTH-bit remainder.
- Used by the neural-network datapath for normalization/averaging stages and as a round-trip checker for multiplier results.
- Valid/ready handshakes on both sides; one division in flight at a time.

Parameters:
- WIDTH, 4: divisor, quotient and remainder width. Dividend is 2*WIDTH.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operands valid.
- in_ready, output, 1: block can accept operands.
- dividend, input, 2*WIDTH: numerator, unsigned.
- divisor, input, WIDTH: denominator, unsigned.
- out_valid, output, 1: result valid; held until accepted.
- out_ready, input, 1: consumer accepts result.
- quotient, output, WIDTH: unsigned quotient.
- remainder, output, WIDTH: unsigned remainder.
- div_by_zero, output, 1: divisor was 0.
- overflow, output, 1: true quotient does not fit in WIDTH bits.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0.
  - quotient, remainder, div_by_zero and overflow all 0.
  - Internal shift registers and iteration counter cleared.
- Reset mid-operation aborts the division: no result is produced, and in_ready=1 on the first clock after release.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register the operands and compute the flags from those operands:
    - div_by_zero = (divisor==0)
    - overflow = !div_by_zero && (dividend[2W-1:W] >= divisor)
  - If either flag is set, go to DONE. Otherwise go to BUSY with counter=WIDTH.
- State BUSY:
  - in_ready=0.
  - Each cycle, one restoring step:
    - Shift {rem, dividend_low} left by 1.
    - Trial-subtract divisor from the (WIDTH+1)-bit partial remainder.
    - If non-negative: keep the difference and shift a 1 into the quotient. Otherwise restore and shift in 0.
  - Decrement the counter; at counter==1 go to DONE.
  - Partial remainder is WIDTH+1 bits, so no carry is lost.
- State DONE:
  - out_valid=1; quotient, remainder and flags are stable while out_valid=1.
  - On out_ready, go to IDLE.
  - in_ready stays 0 in DONE: no accept in the same cycle as result drain.
- Error results:
  - div_by_zero: quotient={WIDTH{1}}, remainder=dividend[W-1:0], overflow=0.
  - overflow: quotient={WIDTH{1}}, remainder=dividend[W-1:0].
- Latency:
  - Normal division: accept edge, then WIDTH BUSY cycles. out_valid rises WIDTH+1 cycles after the accept edge (5 for WIDTH=4).
  - Error path: out_valid 1 cycle after accept.
- Backpressure: out_ready may stay low indefinitely; outputs hold.
- in_valid while not ready is ignored; the source must hold its operands.
- Invariant (no error): quotient*divisor + remainder == dividend, and remainder < divisor.

Optional Feature:
- Macro: DIVIDER_FASTPATH_EN.
- Defined: in IDLE, divisor==1 with no overflow goes straight to DONE. Result is quotient=dividend[W-1:0], remainder=0, latency 1 cycle.
- Undefined: divisor==1 takes the normal WIDTH-iteration path.
- Results are identical either way; only latency differs.

Decomposition:
- Package divider_pkg holds:
  - state enum: IDLE, BUSY, DONE
  - DIV_WIDTH_DEFAULT = 4
  - saturating quotient constant (all ones)
- One natural sub-module: div_step. It is combinational; inputs are partial remainder, divisor and next dividend bit; outputs are new remainder and quotient bit. It is instantiated once and iterated.
- FSM, counter and handshake stay in divider_seq.

Test Plan:
- 54/9:
  - dividend=8'h36, divisor=4'h9 -> quotient=6, remainder=0, flags 0.
  - out_valid exactly 5 cycles after accept.
- Sweep:
  - 30/3 -> 10 r0
  - 55/5 -> 11 r0
  - 84/12 -> 7 r0
  - 100/7 -> 14 r2
  - 143/13 -> 11 r0
  - Exhaustive 0..255 / 1..15 with no overflow must satisfy the invariant.
- Errors:
  - 8'h36/0 -> div_by_zero=1, quotient=4'hF, remainder=4'h6, 1-cycle latency.
  - 8'hA0/5 -> overflow=1, quotient=4'hF, remainder=0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after 100/7: outputs stable, in_ready=0.
  - Ignored in_valid pulse causes no state change; release -> IDLE next cycle.
- Reset mid-op:
  - Assert rst_n=0 at BUSY iteration 2 of 84/12 -> all outputs 0 immediately, in_ready=1 after release.
  - Next division 54/9 correct.
- With DIVIDER_FASTPATH_EN:
  - 8'h0B/1 -> quotient=11, remainder=0, out_valid 1 cycle after accept.
  - Without the macro, same result at 5 cycles.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the FSM state encoding, default width and the saturated quotient pattern.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_WIDTH_DEFAULT = 4;

    // All-ones pattern; users slice the low WIDTH bits for the saturated quotient.
    localparam logic [31:0] QUO_SAT_ALL = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
// Combinational, zero latency; no flow control (driven by the divider_seq FSM).
// No backpressure of its own.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dvd_bit,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // WIDTH+1 bits so the bit shifted out of the remainder is never lost.
    logic [WIDTH:0] part;

    always_comb begin
        part    = {rem_in, dvd_bit};
        q_bit   = (part >= {1'b0, divisor});
        rem_out = q_bit ? WIDTH'(part - {1'b0, divisor}) : part[WIDTH-1:0];
    end

endmodule

// File: rtl/divider_seq.sv
// Iterative unsigned restoring divider, 2*WIDTH / WIDTH -> WIDTH quotient + remainder.
// Latency: out_valid WIDTH+1 edges after accept (1 edge for error results, or divisor==1 with DIVIDER_FASTPATH_EN).
// Backpressure: one op in flight; result held until out_ready, in_ready low from accept until drain.
module divider_seq
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] QUO_SAT = QUO_SAT_ALL[WIDTH-1:0];

    state_t           state;
    logic [WIDTH-1:0] dvd_lo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    // remainder doubles as the partial remainder and quotient as the quotient shift register.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (remainder),
        .divisor (dvs),
        .dvd_bit (dvd_lo[WIDTH-1]),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            dvd_lo      <= '0;
            dvs         <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        dvs    <= divisor;
                        dvd_lo <= dividend[WIDTH-1:0];
                        cnt    <= CW'(WIDTH);
                        if (divisor == '0) begin
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            quotient    <= QUO_SAT;
                            remainder   <= dividend[WIDTH-1:0];
                            state       <= DONE;
                            in_ready    <= 1'b0;
                            out_valid   <= 1'b1;
                        end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                            quotient    <= QUO_SAT;
                            remainder   <= dividend[WIDTH-1:0];
                            state       <= DONE;
                            in_ready    <= 1'b0;
                            out_valid   <= 1'b1;
`ifdef DIVIDER_FASTPATH_EN
                        end else if (divisor == WIDTH'(1)) begin
                            // High half is zero here, so the quotient is just the low half.
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                            quotient    <= dividend[WIDTH-1:0];
                            remainder   <= '0;
                            state       <= DONE;
                            in_ready    <= 1'b0;
                            out_valid   <= 1'b1;
`endif
                        end else begin
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                            quotient    <= '0;
                            remainder   <= dividend[2*WIDTH-1:WIDTH];
                            state       <= BUSY;
                            in_ready    <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    remainder <= step_rem;
                    quotient  <= (quotient << 1) | WIDTH'(step_q);
                    dvd_lo    <= dvd_lo << 1;
                    cnt       <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Randomized and directed checks of divider_seq against a plain-arithmetic reference.
module tb_divider_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    divider_seq #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: ordinary integer division with the saturating error rules.
    function automatic void model(input int a, input int b,
                                  output int q, output int r, output int dz, output int ov);
        dz = 0; ov = 0;
        if (b == 0) begin
            dz = 1; q = 15; r = a % 16;
        end else if (a / b > 15) begin
            ov = 1; q = 15; r = a % 16;
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    function automatic int exp_lat(input int a, input int b);
        if (b == 0 || a / b > 15) return 1;
`ifdef DIVIDER_FASTPATH_EN
        if (b == 1) return 1;
`endif
        return 5;
    endfunction

    // Called at #1 after a posedge with in_ready expected high.
    task automatic issue(input int a, input int b);
        in_valid = 1'b1;
        dividend = 8'(a);
        divisor  = 4'(b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
    endtask

    // Counts edges from the accept edge (inclusive) until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_res(input string tag, input int a, input int b);
        int q, r, dz, ov;
        model(a, b, q, r, dz, ov);
        check({tag, ".vld"}, 32'(out_valid), 1);
        check({tag, ".q"}, 32'(quotient), 32'(q));
        check({tag, ".r"}, 32'(remainder), 32'(r));
        check({tag, ".dz"}, 32'(div_by_zero), 32'(dz));
        check({tag, ".ov"}, 32'(overflow), 32'(ov));
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".rdy_after"}, 32'(in_ready), 1);
        check({tag, ".vld_after"}, 32'(out_valid), 0);
    endtask

    task automatic run(input string tag, input int a, input int b, input bit chk_lat);
        int lat;
        check({tag, ".rdy"}, 32'(in_ready), 1);
        issue(a, b);
        wait_out(lat);
        if (chk_lat) check({tag, ".lat"}, 32'(lat), 32'(exp_lat(a, b)));
        check_res(tag, a, b);
        drain(tag);
    endtask

    initial begin
        int lat;
        int bad;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.rdy", 32'(in_ready), 1);
        check("rst.vld", 32'(out_valid), 0);
        check("rst.q", 32'(quotient), 0);
        check("rst.r", 32'(remainder), 0);
        check("rst.flags", 32'({div_by_zero, overflow}), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run("d54_9", 54, 9, 1'b1);
        run("d30_3", 30, 3, 1'b1);
        run("d55_5", 55, 5, 1'b1);
        run("d84_12", 84, 12, 1'b1);
        run("d100_7", 100, 7, 1'b1);
        run("d143_13", 143, 13, 1'b1);
        run("dz", 8'h36, 0, 1'b1);
        run("ovf", 8'hA0, 5, 1'b1);
        run("one", 8'h0B, 1, 1'b1);

        // Backpressure: result and in_ready hold; a stray in_valid is ignored.
        issue(100, 7);
        wait_out(lat);
        check("bp.lat", 32'(lat), 5);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 4);
            dividend = 8'h36;
            divisor  = 4'h9;
            @(posedge clk);
            #1;
            check("bp.q", 32'(quotient), 14);
            check("bp.r", 32'(remainder), 2);
            check("bp.vld", 32'(out_valid), 1);
            check("bp.rdy", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        drain("bp");

        // Reset in the middle of a division aborts it.
        issue(84, 12);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid.vld", 32'(out_valid), 0);
        check("mid.rdy", 32'(in_ready), 1);
        check("mid.q", 32'(quotient), 0);
        check("mid.r", 32'(remainder), 0);
        check("mid.flags", 32'({div_by_zero, overflow}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid.rdy_rel", 32'(in_ready), 1);
        check("mid.vld_rel", 32'(out_valid), 0);
        run("post_rst", 54, 9, 1'b1);

        // Exhaustive sweep including error cases, with the algebraic invariant.
        bad = 0;
        for (int b = 0; b < 16; b++) begin
            for (int a = 0; a < 256; a++) begin
                issue(a, b);
                wait_out(lat);
                if (lat != exp_lat(a, b)) check("sweep.lat", 32'(lat), 32'(exp_lat(a, b)));
                check_res("sweep", a, b);
                if (b != 0 && a / b < 16) begin
                    check("sweep.inv", 32'(int'(quotient) * b + int'(remainder)), 32'(a));
                    check("sweep.rlt", 32'(int'(remainder) < b), 1);
                end
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                out_ready = 1'b0;
            end
        end

        // Random operands with random idle gaps and random drain delays.
        for (int n = 0; n < 200; n++) begin
            int a, b;
            a = int'($urandom_range(255, 0));
            b = int'($urandom_range(15, 0));
            repeat ($urandom_range(2, 0)) begin
                @(posedge clk);
                #1;
            end
            check("rnd.rdy", 32'(in_ready), 1);
            issue(a, b);
            wait_out(lat);
            check("rnd.lat", 32'(lat), 32'(exp_lat(a, b)));
            repeat ($urandom_range(3, 0)) begin
                @(posedge clk);
                #1;
            end
            check_res("rnd", a, b);
            drain("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
